// File: rtl/spike_decoder.sv
// spike_decoder
//   Output-layer decoder for the spiking network. It counts signed spikes per
//   output neuron over a fixed window and keeps each lane score saturating and
//   floored at zero. It then scans the lanes one per cycle to pick the winner
//   and holds the winner's index and score on a valid/ready handshake.
//
// Ports
//   clk          : rising-edge clock
//   rst          : asynchronous active-high reset
//   start        : begin a decode (sampled only in IDLE)
//   spike_data   : per-lane spike present
//   spike_sign   : per-lane polarity, 1 = positive, 0 = negative
//   busy         : high whenever not IDLE
//   result_valid : result available
//   result_ready : consumer accepts the result
//   result_idx   : winning lane
//   result_score : winning lane's score
//   result_none  : all scores zero at end of window
module spike_decoder #(
  parameter int unsigned N_OUT      = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned WIN_CYCLES = 64,
  parameter int unsigned IDX_W      = $clog2(N_OUT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_OUT-1:0] spike_data,
  input  logic [N_OUT-1:0] spike_sign,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [IDX_W-1:0] result_idx,
  output logic [CNT_W-1:0] result_score,
  output logic             result_none
);

  localparam int unsigned       WC_W      = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
  localparam logic [WC_W-1:0]   WIN_LAST  = WC_W'(WIN_CYCLES - 1);
  localparam logic [IDX_W-1:0]  SCAN_LAST = IDX_W'(N_OUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    SCAN,
    HOLD
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_score [N_OUT];
  logic [WC_W-1:0]  r_win_cnt;
  logic [IDX_W-1:0] r_scan_ptr;
  logic [IDX_W-1:0] r_best_idx;
  logic [CNT_W-1:0] r_best_score;
  logic             r_busy;
  logic             r_result_valid;
  logic [IDX_W-1:0] r_result_idx;
  logic [CNT_W-1:0] r_result_score;
  logic             r_result_none;

  logic [CNT_W-1:0] w_cur_score;
  logic             w_take;
  logic [IDX_W-1:0] w_next_idx;
  logic [CNT_W-1:0] w_next_score;

  // Running best including the lane under the scan pointer; strict compare
  // keeps the lowest index on a tie.
  always_comb begin
    w_cur_score  = r_score[r_scan_ptr];
    w_take       = (w_cur_score > r_best_score);
    w_next_idx   = w_take ? r_scan_ptr : r_best_idx;
    w_next_score = w_take ? w_cur_score : r_best_score;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      for (int unsigned i = 0; i < N_OUT; i++) r_score[i] <= '0;
      r_win_cnt      <= '0;
      r_scan_ptr     <= '0;
      r_best_idx     <= '0;
      r_best_score   <= '0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_idx   <= '0;
      r_result_score <= '0;
      r_result_none  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state      <= COUNT;
            r_busy       <= 1'b1;
            for (int unsigned i = 0; i < N_OUT; i++) r_score[i] <= '0;
            r_win_cnt    <= '0;
            r_scan_ptr   <= '0;
            r_best_idx   <= '0;
            r_best_score <= '0;
          end
        end

        COUNT: begin
          for (int unsigned i = 0; i < N_OUT; i++) begin
            if (spike_data[i]) begin
              if (spike_sign[i]) begin
                if (r_score[i] != '1) r_score[i] <= r_score[i] + CNT_W'(1);
              end else begin
                if (r_score[i] != '0) r_score[i] <= r_score[i] - CNT_W'(1);
              end
            end
          end
          r_win_cnt <= r_win_cnt + WC_W'(1);
          if (r_win_cnt == WIN_LAST) begin
            r_state    <= SCAN;
            r_scan_ptr <= '0;
          end
        end

        SCAN: begin
          r_best_idx   <= w_next_idx;
          r_best_score <= w_next_score;
          if (r_scan_ptr == SCAN_LAST) begin
            // Last lane folds straight into the result registers.
            r_state        <= HOLD;
            r_result_valid <= 1'b1;
            r_result_idx   <= w_next_idx;
            r_result_score <= w_next_score;
            r_result_none  <= (w_next_score == '0);
          end else begin
            r_scan_ptr <= r_scan_ptr + IDX_W'(1);
          end
        end

        HOLD: begin
          if (result_ready) begin
            r_state        <= IDLE;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign result_valid = r_result_valid;
  assign result_idx   = r_result_idx;
  assign result_score = r_result_score;
  assign result_none  = r_result_none;

endmodule

// File: tb/tb_spike_decoder.sv
// tb_spike_decoder
//   Table-driven bench for spike_decoder: directed and random spike windows
//   compared against a score/argmax reference model, plus hand-written
//   sequences for saturation, reset mid-decode and backpressure in HOLD.
module tb_spike_decoder;

  localparam int N  = 4;
  localparam int WC = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] spike_data;
  logic [N-1:0] spike_sign;
  logic         busy;
  logic         result_valid;
  logic         result_ready;
  logic [1:0]   result_idx;
  logic [7:0]   result_score;
  logic         result_none;

  logic         start2;
  logic [N-1:0] data2;
  logic [N-1:0] sign2;
  logic         busy2;
  logic         valid2;
  logic         ready2;
  logic [1:0]   idx2;
  logic [3:0]   score2;
  logic         none2;

  spike_decoder #(.N_OUT(4), .CNT_W(8), .WIN_CYCLES(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .spike_data   (spike_data),
    .spike_sign   (spike_sign),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_idx   (result_idx),
    .result_score (result_score),
    .result_none  (result_none)
  );

  spike_decoder #(.N_OUT(4), .CNT_W(4), .WIN_CYCLES(32)) dut_sat (
    .clk          (clk),
    .rst          (rst),
    .start        (start2),
    .spike_data   (data2),
    .spike_sign   (sign2),
    .busy         (busy2),
    .result_valid (valid2),
    .result_ready (ready2),
    .result_idx   (idx2),
    .result_score (score2),
    .result_none  (none2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WC*N-1:0] d;
    logic [WC*N-1:0] s;
    int              e_idx;
    int              e_score;
    int              e_none;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: plain integer scores clamped to [0,255], then argmax with
  // a strict compare against a best starting at zero.
  function automatic void model(inout vec_t v);
    int sc [N];
    for (int l = 0; l < N; l++) sc[l] = 0;
    for (int c = 0; c < WC; c++)
      for (int l = 0; l < N; l++)
        if (v.d[c*N+l]) begin
          if (v.s[c*N+l]) sc[l] = (sc[l] + 1 > 255) ? 255 : sc[l] + 1;
          else            sc[l] = (sc[l] - 1 < 0)   ? 0   : sc[l] - 1;
        end
    v.e_idx   = 0;
    v.e_score = 0;
    for (int l = 0; l < N; l++)
      if (sc[l] > v.e_score) begin
        v.e_idx   = l;
        v.e_score = sc[l];
      end
    v.e_none = (v.e_score == 0) ? 1 : 0;
  endfunction

  task automatic run_vec(input vec_t v, input string tag, input int hold_n);
    int k;
    result_ready = (hold_n == 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);               // after edge 0
    start = 1'b0;
    check({tag, "_busy_rise"}, busy, 1);
    k = 0;
    while (k < 60) begin
      if (k < WC) begin
        spike_data = v.d[k*N +: N];
        spike_sign = v.s[k*N +: N];
      end else begin
        spike_data = '0;
        spike_sign = '0;
      end
      @(negedge clk);
      k++;
      if (result_valid) break;
    end
    check({tag, "_latency"}, k, WC + N);
    check({tag, "_idx"},   result_idx,   v.e_idx);
    check({tag, "_score"}, result_score, v.e_score);
    check({tag, "_none"},  result_none,  v.e_none);
    for (int h = 0; h < hold_n; h++) begin
      start = h[0];
      @(negedge clk);
      check({tag, "_hold_valid"}, result_valid, 1);
      check({tag, "_hold_busy"},  busy,         1);
      check({tag, "_hold_idx"},   result_idx,   v.e_idx);
      check({tag, "_hold_score"}, result_score, v.e_score);
      check({tag, "_hold_none"},  result_none,  v.e_none);
    end
    result_ready = 1'b1;
    if (hold_n > 0) start = 1'b1;  // lands on the handover edge
    @(negedge clk);
    start = 1'b0;
    check({tag, "_valid_drop"}, result_valid, 0);
    check({tag, "_busy_fall"},  busy,         0);
    if (hold_n > 0) begin
      @(negedge clk);
      check({tag, "_start_at_handover_ignored"}, busy, 0);
    end
  endtask

  vec_t tbl [24];

  initial begin
    int k;
    int bad;
    rst = 1'b1;
    start = 1'b0;
    spike_data = '0;
    spike_sign = '0;
    result_ready = 1'b1;
    start2 = 1'b0;
    data2 = '0;
    sign2 = '0;
    ready2 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy",  busy,         0);
    check("rst_valid", result_valid, 0);
    check("rst_idx",   result_idx,   0);
    check("rst_score", result_score, 0);
    check("rst_none",  result_none,  0);
    check("rst_valid_sat", valid2, 0);
    rst = 1'b0;

    // Directed rows.
    for (int i = 0; i < 24; i++) begin
      tbl[i].d = '0;
      tbl[i].s = '0;
    end
    for (int c = 0; c < WC; c++) begin           // basic winner
      tbl[0].d[c*N+2] = 1'b1;
      tbl[0].s[c*N+2] = 1'b1;
      if (c % 2 == 0) begin
        tbl[0].d[c*N+1] = 1'b1;
        tbl[0].s[c*N+1] = 1'b1;
      end
    end
    tbl[0].e_idx = 2; tbl[0].e_score = 16; tbl[0].e_none = 0;
    for (int c = 0; c < 8; c++) begin            // negative floor
      tbl[1].d[c*N+0] = 1'b1;
      tbl[1].s[c*N+0] = (c >= 3);
    end
    for (int c = 0; c < 2; c++) begin
      tbl[1].d[c*N+3] = 1'b1;
      tbl[1].s[c*N+3] = 1'b1;
    end
    tbl[1].e_idx = 0; tbl[1].e_score = 5; tbl[1].e_none = 0;
    for (int c = 0; c < WC; c++) begin           // tie + ignored sign
      tbl[2].s[c*N+2] = 1'b1;
      if (c < 4) begin
        tbl[2].d[c*N+1] = 1'b1; tbl[2].s[c*N+1] = 1'b1;
        tbl[2].d[c*N+3] = 1'b1; tbl[2].s[c*N+3] = 1'b1;
      end
    end
    tbl[2].e_idx = 1; tbl[2].e_score = 4; tbl[2].e_none = 0;
    tbl[3].s = {$urandom, $urandom};             // no activity
    tbl[3].e_idx = 0; tbl[3].e_score = 0; tbl[3].e_none = 1;
    for (int i = 4; i < 24; i++) begin
      tbl[i].d = {$urandom, $urandom};
      if (i % 2 == 0) tbl[i].d &= {$urandom, $urandom};
      tbl[i].s = {$urandom, $urandom} | {$urandom, $urandom};
      model(tbl[i]);
    end

    for (int i = 0; i < 24; i++) run_vec(tbl[i], $sformatf("v%0d", i), 0);

    // Saturation: 4-bit scores over 32 cycles; lane 1 pinned at the floor.
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    k = 0;
    while (k < 80) begin
      data2 = (k < 32) ? 4'b0011 : 4'b0000;
      sign2 = (k < 32) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      k++;
      if (valid2) break;
    end
    check("sat_latency", k, 36);
    check("sat_score",   score2, 15);
    check("sat_idx",     idx2,   0);
    check("sat_none",    none2,  0);
    @(negedge clk);
    check("sat_busy_fall", busy2, 0);

    // Reset mid-COUNT after a result left non-zero outputs behind.
    run_vec(tbl[0], "pre_rst", 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    spike_data = 4'b0100;
    spike_sign = 4'b0100;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy",  busy,         0);
    check("midrst_valid", result_valid, 0);
    check("midrst_idx",   result_idx,   0);
    check("midrst_score", result_score, 0);
    check("midrst_none",  result_none,  0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (result_valid || busy) bad++;
    end
    check("midrst_no_result", bad, 0);
    spike_data = '0;
    spike_sign = '0;

    // Backpressure: ten cycles of result_ready=0 with start toggling.
    run_vec(tbl[1], "bp", 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
